// File: rtl/qpp_address_gen.sv
// QPP turbo-interleaver address generator.
// Walks i = 0..K-1 and presents pi(i) = (f1*i + f2*i^2) mod K for each step.
// The address is built incrementally:
//   pi(i+1) = pi(i) + g(i)  (mod K)
//   g(i+1)  = g(i) + 2*f2   (mod K)
//   g(0)    = f1 + f2       (mod K)
// Only modular adders are used; there are no multipliers.
//
// state | meaning
// IDLE  | waiting for start; outputs hold, addr_valid low
// RUN   | index/addr hold a valid pair; advance steps to the next index
// DONE  | one-cycle done pulse after the last address was accepted
module qpp_address_gen #(
  parameter int AW      = 13,
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          block_size,
  input  logic          advance,
  output logic [AW-1:0] index,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          busy,
  output logic          done
);

  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  localparam logic [AW-1:0] K_S     = AW'(K_SMALL);
  localparam logic [AW-1:0] K_L     = AW'(K_LARGE);
  localparam logic [AW-1:0] G0_S    = AW'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [AW-1:0] G0_L    = AW'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [AW-1:0] STEP2_S = AW'((2 * F2_SMALL) % K_SMALL);
  localparam logic [AW-1:0] STEP2_L = AW'((2 * F2_LARGE) % K_LARGE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          size_q;
  logic [AW-1:0] index_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] g_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] k_r;
  logic [AW-1:0] step2_r;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] g_d;

  // Both operands are below k, so one conditional subtract brings the sum back into range.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b,
                                             input logic [AW-1:0] k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) begin
      s = s - {1'b0, k};
    end
    return s[AW-1:0];
  endfunction

  // Block constants follow the size latched at start; next address and increment.
  always_comb begin
    k_r      = size_q ? K_L : K_S;
    step2_r  = size_q ? STEP2_L : STEP2_S;
    last_idx = k_r - AW'(1);
    addr_d   = mod_add(addr_q, g_q, k_r);
    g_d      = mod_add(g_q, step2_r, k_r);
  end

  // Sequencing FSM with registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      size_q  <= 1'b0;
      index_q <= '0;
      addr_q  <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            size_q  <= block_size;
            index_q <= '0;
            addr_q  <= '0;
            g_q     <= block_size ? G0_L : G0_S;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (advance) begin
            if (index_q == last_idx) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              index_q <= index_q + AW'(1);
              addr_q  <= addr_d;
              g_q     <= g_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign index      = index_q;
  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_qpp_address_gen.sv
// Bench for qpp_address_gen: stimulus pushes the expected (index, addr) stream
// of each block it starts; a monitor compares whatever the DUT presents.
module tb_qpp_address_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        block_size;
  logic        advance;
  logic [12:0] index;
  logic [12:0] addr;
  logic        addr_valid;
  logic        busy;
  logic        done;

  qpp_address_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .block_size(block_size),
    .advance   (advance),
    .index     (index),
    .addr      (addr),
    .addr_valid(addr_valid),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int idx;
    int ad;
    bit sz;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seen[6144];
  int   hand_s[int];
  int   hand_l[int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Closed-form reference: pi(i) = (f1*i + f2*i*i) mod K.
  task automatic push_block(input bit sz);
    int     k;
    longint f1, f2, li;
    exp_t   e;
    k  = sz ? 6144 : 1056;
    f1 = sz ? 263 : 17;
    f2 = sz ? 480 : 66;
    for (int i = 0; i < k; i++) begin
      li     = longint'(i);
      e.idx  = i;
      e.ad   = int'((f1 * li + f2 * li * li) % longint'(k));
      e.sz   = sz;
      e.last = (i == k - 1);
      sb.push_back(e);
    end
  endtask

  task automatic start_block(input bit sz);
    push_block(sz);
    start      = 1'b1;
    block_size = sz;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: advance held; 1: random advance; 2: advance held, start/block_size toggled randomly
  task automatic run_until_done(input int mode, input int limit, input string nm);
    bit got;
    got = 1'b0;
    for (int c = 0; c < limit; c++) begin
      case (mode)
        1: advance = 1'($urandom_range(0, 1));
        2: begin
          advance    = 1'b1;
          start      = 1'($urandom_range(0, 1));
          block_size = 1'($urandom_range(0, 1));
        end
        default: advance = 1'b1;
      endcase
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(nm, int'(got), 1);
    advance = 1'b0;
  endtask

  // Monitor: compare the presented pair against the scoreboard front; pop on acceptance.
  exp_t mon_e;
  int   mon_k;
  bit   exp_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (addr_valid) begin
        if (sb.size() == 0) begin
          chk("valid_with_empty_scoreboard", 1, 0);
        end else begin
          mon_e = sb[0];
          mon_k = mon_e.sz ? 6144 : 1056;
          chk("index", int'(index), mon_e.idx);
          chk("addr", int'(addr), mon_e.ad);
          chk("busy_in_run", int'(busy), 1);
          chk("addr_and_g_below_k", int'((int'(addr) < mon_k) && (int'(dut.g_q) < mon_k)), 1);
          if (mon_e.sz && hand_l.exists(mon_e.idx))
            chk("hand_addr_large", int'(addr), hand_l[mon_e.idx]);
          if (!mon_e.sz && hand_s.exists(mon_e.idx))
            chk("hand_addr_small", int'(addr), hand_s[mon_e.idx]);
          if (advance) begin
            void'(sb.pop_front());
            if (int'(addr) < 6144) seen[int'(addr)]++;
            exp_done = mon_e.last;
          end
        end
      end else if (done || exp_done) begin
        chk("done_pulse", int'(done), int'(exp_done));
        chk("busy_in_done", int'(busy), 0);
        exp_done = 1'b0;
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    block_size = 1'b0;
    advance    = 1'b0;
    hand_s[0] = 0;    hand_s[1] = 83;   hand_s[2] = 298;  hand_s[3] = 645;  hand_s[1055] = 49;
    hand_l[0] = 0;    hand_l[1] = 743;  hand_l[2] = 2446; hand_l[3] = 5109; hand_l[4] = 2588;
    hand_l[6143] = 217;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_index", int'(index), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_addr_valid", int'(addr_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // small block, advance held high
    start_block(1'b0);
    run_until_done(0, 1200, "small_block_done_seen");
    chk("small_final_index", int'(index), 1055);
    chk("small_final_addr", int'(addr), 49);
    @(posedge clk); #1;

    // large block, advance held high
    start_block(1'b1);
    run_until_done(0, 6300, "large_block_done_seen");
    chk("large_final_index", int'(index), 6143);
    chk("large_final_addr", int'(addr), 217);
    @(posedge clk); #1;

    // small block with random stalls; result must be a permutation of 0..1055
    for (int i = 0; i < 6144; i++) seen[i] = 0;
    start_block(1'b0);
    run_until_done(1, 5000, "stalled_block_done_seen");
    @(posedge clk); #1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1056; i++) if (seen[i] != 1) bad++;
      chk("permutation_bad_entries", bad, 0);
    end

    // reset mid-block at index 500
    start_block(1'b0);
    advance = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    chk("index_before_reset", int'(index), 500);
    reset   = 1'b0;
    advance = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("midreset_addr_valid", int'(addr_valid), 0);
    chk("midreset_index", int'(index), 0);
    chk("midreset_addr", int'(addr), 0);
    chk("midreset_busy", int'(busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    start_block(1'b0);
    run_until_done(0, 1200, "restart_after_reset_done_seen");
    @(posedge clk); #1;

    // start/block_size noise during RUN, then start in DONE
    start_block(1'b0);
    run_until_done(2, 1200, "noisy_start_block_done_seen");
    chk("noisy_final_index", int'(index), 1055);
    chk("noisy_final_addr", int'(addr), 49);
    start      = 1'b1;
    block_size = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("after_done_idle_valid", int'(addr_valid), 0);
    chk("after_done_idle_done", int'(done), 0);
    @(posedge clk); #1;
    chk("start_in_done_ignored", int'(addr_valid), 0);
    chk("start_in_done_ignored_busy", int'(busy), 0);
    start_block(1'b0);
    run_until_done(0, 1200, "idle_start_accepted_done_seen");
    @(posedge clk); #1;

    // reset and start together: reset wins
    reset      = 1'b0;
    start      = 1'b1;
    block_size = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    chk("reset_vs_start_valid", int'(addr_valid), 0);
    chk("reset_vs_start_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("reset_vs_start_still_idle", int'(addr_valid), 0);

    // start held: back-to-back blocks with one DONE and one IDLE cycle between
    push_block(1'b0);
    push_block(1'b0);
    start      = 1'b1;
    block_size = 1'b0;
    @(posedge clk); #1;
    run_until_done(0, 1200, "b2b_first_done_seen");
    @(posedge clk); #1;
    chk("b2b_gap_idle_valid", int'(addr_valid), 0);
    chk("b2b_gap_idle_done", int'(done), 0);
    @(posedge clk); #1;
    chk("b2b_second_valid", int'(addr_valid), 1);
    chk("b2b_second_index", int'(index), 0);
    start = 1'b0;
    run_until_done(0, 1200, "b2b_second_done_seen");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qpp_address_gen.md
Name: qpp_address_gen

Overview:
Downstream of the block counter. Consumes the sequential write/read index (0..K-1) and produces the QPP turbo-interleaver address pi(i) = (f1*i + f2*i^2) mod K, one address per accepted step. It supports the two block sizes K=1056 and K=6144. The address is computed incrementally with modular adders only, with no multipliers. It feeds the interleaver memory read-address port.

Parameters:
- AW, 13, address/index width (must hold 6143).
- K_SMALL, 1056, small block size; f1=17, f2=66.
- K_LARGE, 6144, large block size; f1=263, f2=480.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- start  in  1  begin a block; sampled only in IDLE.
- block_size  in  1  0 = small (1056), 1 = large (6144); latched on accepted start.
- advance  in  1  consumer accepts current addr; step to next index.
- index  out  AW  current sequential index i.
- addr  out  AW  pi(i) for current index.
- addr_valid  out  1  index/addr hold a valid pair.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after last address accepted.

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE.
  - index=0, addr=0, addr_valid=0, busy=0, done=0.
  - Internal g=0, size latch=0.
  - Reset overrides everything, including mid-block.
- Internal registers:
  - K_r, f1_r, and step2 = 2*f2 mod K, all selected by the latched size (small: 132; large: 960).
  - Increment register g (AW bits).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches block_size.
  - Next cycle: index=0, addr=0, g=(f1+f2) mod K (small 83, large 743), addr_valid=1, busy=1, state goes to RUN.
  - start=0 leaves all outputs held; addr_valid=0.
- RUN, advance=1 and index != K-1:
  - index <= index+1.
  - addr <= (addr+g) mod K.
  - g <= (g+step2) mod K.
  - Results appear the following cycle (1-cycle step latency); addr_valid stays 1.
- RUN, advance=0: all registers hold (stall); addr_valid stays 1.
- RUN, advance=1 and index == K-1:
  - State goes to DONE; addr_valid <= 0, busy <= 0, done <= 1.
  - index/addr hold their last values.
- DONE: done=1 for exactly one cycle, then IDLE with done=0. A start during DONE is ignored.
- Modular add rule:
  - Operands are < K. Form a 14-bit sum; if sum >= K, subtract K.
  - No operand may ever reach K; a bench assertion checks addr < K and g < K at all times.
- start and block_size changes while busy are ignored; the latched size is used until DONE.
- advance is ignored outside RUN.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then start with block_size=0, advance held at 1 -> addr sequence 0, 83, 298, 645, ...; after 1056 valid cycles index=1055, addr=49; done pulses once; addr_valid drops the same cycle.
- start with block_size=1, advance=1 -> addr 0, 743, 2446, 5109, 2588 (first wrap); final index=6143, addr=217; done pulses once.
- Small block with advance toggled randomly -> addr/index hold during advance=0. The full 1056-entry sequence matches the closed-form reference model and is a permutation: every value 0..1055 appears exactly once.
- Drive reset=0 mid-block at index 500 -> the next cycle shows IDLE, addr_valid=0, index=0, addr=0. A subsequent start restarts from addr 0.
- Pulse start and flip block_size during RUN of a small block -> no restart; the block still ends at index 1055 with addr 49. A start pulsed in the DONE cycle is ignored; a start in IDLE afterwards is accepted.
- Assert reset=0 with start=1 simultaneously -> reset wins and the block stays IDLE. Hold start=1 continuously -> blocks run back-to-back with exactly one DONE cycle and one IDLE cycle between them.
